div_unit: RTL and testbench

//  Multi-cycle DIV/DIVU engine beside the EX stage; result goes to the HI/LO write path.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the DIV/DIVU engine and its HI/LO write path.
package div_unit_pkg;

   typedef logic [31:0] reg_data_t;

   localparam logic REG_ENABLE  = 1'b1;
   localparam logic REG_DISABLE = 1'b0;

   typedef struct packed {
      logic      en;
      reg_data_t hi;
      reg_data_t lo;
   } hilo_t;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_ZERO,
      DIV_ON,
      DIV_END
   } div_state_t;

   localparam int        DIV_CYCLES    = 32;
   localparam reg_data_t DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU engine: one quotient bit per cycle, quotient to LO, remainder to HI.
// Optional feature macro: DIV_ANNUL_EN (annul_i cancels an in-flight operation).
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              annul_i,
   output logic              busy_o,
   output logic              ready_o,
   output hilo_t             hilo_o
);

   div_state_t        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic              neg_quot_q, neg_quot_d;
   logic              neg_rem_q, neg_rem_d;

   logic              annul_w;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] rem_nxt;
   logic [DATA_W-1:0] quot_nxt;

`ifdef DIV_ANNUL_EN
   assign annul_w = annul_i;
`else
   logic unused_annul;
   assign unused_annul = annul_i;
   assign annul_w      = 1'b0;
`endif

   function automatic reg_data_t abs_val(input reg_data_t v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic reg_data_t sign_fix(input reg_data_t v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   always_comb begin
      shifted  = {rem_q, dvd_q[DATA_W-1]};
      trial    = shifted - {1'b0, dvs_q};
      rem_nxt  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      quot_nxt = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;

      case (state_q)
         DIV_IDLE: begin
            if (start_i && !annul_w) begin
               neg_quot_d = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
               neg_rem_d  = signed_i & dividend_i[DATA_W-1];
               dvs_d      = signed_i ? abs_val(divisor_i) : divisor_i;
               rem_d      = '0;
               cnt_d      = '0;
               if (divisor_i == '0) begin
                  // raw operand kept: it becomes HI unchanged
                  dvd_d   = dividend_i;
                  state_d = DIV_ZERO;
               end else begin
                  dvd_d   = signed_i ? abs_val(dividend_i) : dividend_i;
                  state_d = DIV_ON;
               end
            end
         end
         DIV_ZERO: begin
            if (annul_w) begin
               state_d = DIV_IDLE;
            end else begin
               lo_d    = DIV_ZERO_QUOT;
               hi_d    = dvd_q;
               state_d = DIV_END;
            end
         end
         DIV_ON: begin
            if (annul_w) begin
               state_d = DIV_IDLE;
            end else begin
               rem_d = rem_nxt;
               dvd_d = quot_nxt;
               if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                  lo_d    = sign_fix(quot_nxt, neg_quot_q);
                  hi_d    = sign_fix(rem_nxt, neg_rem_q);
                  cnt_d   = '0;
                  state_d = DIV_END;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         DIV_END: begin
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // operand/iteration datapath needs no reset: always loaded at accept
   always_ff @(posedge clk) begin
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
   end

   assign busy_o    = (state_q == DIV_ON) || (state_q == DIV_ZERO);
   assign ready_o   = (state_q == DIV_END);
   assign hilo_o.en = (state_q == DIV_END) ? REG_ENABLE : REG_DISABLE;
   assign hilo_o.hi = hi_q;
   assign hilo_o.lo = lo_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed quotient/remainder and latency.
module tb_div_unit;
   import div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic        annul_i = 1'b0;
   logic        busy_o;
   logic        ready_o;
   hilo_t       hilo_o;

   int n_cmp = 0;
   int n_bad = 0;

   div_unit #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .annul_i    (annul_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .hilo_o     (hilo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_i   = sgn;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   // lat counts cycles after the accept edge until ready_o is seen (41 = timeout)
   task automatic wait_ready(output int lat, output int bsy);
      lat = 0;
      bsy = 0;
      while (lat <= 40) begin
         @(negedge clk);
         lat++;
         if (busy_o) bsy++;
         if (ready_o) break;
      end
   endtask

   task automatic count_ready(input int cycles, output int pulses);
      pulses = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (ready_o) pulses++;
      end
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat);
      int lat, bsy;
      launch(sgn, a, b);
      wait_ready(lat, bsy);
      check({tag, ".lat"},  64'(lat), 64'(exp_lat));
      check({tag, ".busy"}, 64'(bsy), 64'(exp_lat - 1));
      check({tag, ".en"},   64'(hilo_o.en), 64'(1));
      check({tag, ".lo"},   64'(hilo_o.lo), 64'(exp_lo));
      check({tag, ".hi"},   64'(hilo_o.hi), 64'(exp_hi));
      @(negedge clk);
      check({tag, ".rdy_off"}, 64'(ready_o), 64'(0));
      check({tag, ".en_off"},  64'(hilo_o.en), 64'(0));
      check({tag, ".lo_hold"}, 64'(hilo_o.lo), 64'(exp_lo));
   endtask

   initial begin
      int lat, bsy, pulses;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.busy",  64'(busy_o), 64'(0));
      check("rst.ready", 64'(ready_o), 64'(0));
      check("rst.en",    64'(hilo_o.en), 64'(0));
      check("rst.hi",    64'(hilo_o.hi), 64'(0));
      check("rst.lo",    64'(hilo_o.lo), 64'(0));
      rst = 1'b0;

      run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
      run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
      run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
      run_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
      run_div("div_min_2",   1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          33);
      run_div("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          33);
      run_div("div_m1_16",   1'b1, 32'hFFFF_FFFF,  32'h10,         32'd0,          32'hFFFF_FFFF,  33);
      run_div("divu_5_0",    1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2);
      run_div("div_m8_0",    1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  2);

      // reset while the iteration counter is at 10
      launch(1'b0, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst.busy",  64'(busy_o), 64'(0));
      check("midrst.ready", 64'(ready_o), 64'(0));
      check("midrst.lo",    64'(hilo_o.lo), 64'(0));
      count_ready(40, pulses);
      check("midrst.pulses", 64'(pulses), 64'(0));
      run_div("restart_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // start pulsed mid-operation must be ignored
      launch(1'b0, 32'd20, 32'd3);
      repeat (5) @(negedge clk);
      dividend_i = 32'd50;
      divisor_i  = 32'd5;
      start_i    = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_ready(lat, bsy);
      check("midstart.lo", 64'(hilo_o.lo), 64'(6));
      check("midstart.hi", 64'(hilo_o.hi), 64'(2));
      count_ready(40, pulses);
      check("midstart.pulses", 64'(pulses), 64'(0));

      // annul at counter 5
      launch(1'b0, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1 annul_i = 1'b0;
`ifdef DIV_ANNUL_EN
      @(negedge clk);
      check("annul.busy", 64'(busy_o), 64'(0));
      check("annul.en",   64'(hilo_o.en), 64'(0));
      check("annul.lo",   64'(hilo_o.lo), 64'(6));
      count_ready(40, pulses);
      check("annul.pulses", 64'(pulses), 64'(0));
      @(negedge clk);
      annul_i    = 1'b1;
      start_i    = 1'b1;
      dividend_i = 32'd9;
      divisor_i  = 32'd3;
      @(posedge clk);
      #1 begin
         annul_i = 1'b0;
         start_i = 1'b0;
      end
      @(negedge clk);
      check("annul_idle.busy", 64'(busy_o), 64'(0));
      count_ready(40, pulses);
      check("annul_idle.pulses", 64'(pulses), 64'(0));
`else
      wait_ready(lat, bsy);
      check("annul_off.ready", 64'(ready_o), 64'(1));
      check("annul_off.lo",    64'(hilo_o.lo), 64'(14));
      check("annul_off.hi",    64'(hilo_o.hi), 64'(2));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_div_unit
